cacheline_fill_assembler: RTL and testbench

- Write-side counterpart to the fetch-stage line parser. It collects a stream of 32-bit words returned by the memory bus after a cache miss and assembles them into a full cacheline.
- The line is filled critical-word-first with wrap-around.
- The completed line is presented, with its tag and index, to the cache write port through a valid/ready handshake.

---
 rtl/cacheline_fill_assembler.sv | 163 ++++++++++++++++
 tb/tb_cacheline_fill_assembler.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_fill_assembler.sv
// rtl/cacheline_fill_assembler.sv - critical-word-first cacheline fill assembler (option: CACHELINE_CRITICAL_WORD_FORWARD_EN)
module cacheline_fill_assembler #(
  parameter int offsetSize          = 5,
  parameter int indexSize           = 8,
  parameter int tagSize             = 64 - (offsetSize + indexSize),
  parameter int cachelineSizeInBits = (2 ** offsetSize) * 8,
  parameter int wordSizeBits        = 32
) (
  input  logic                           clock_i,
  input  logic                           reset_n_i,
  input  logic                           flushPipeline_i,
  input  logic                           start_i,
  input  logic [tagSize-1:0]             startTag_i,
  input  logic [indexSize-1:0]           startIndex_i,
  input  logic [offsetSize-1:0]          startOffset_i,
  output logic                           busy_o,
  input  logic                           wordValid_i,
  input  logic [wordSizeBits-1:0]        word_i,
  output logic                           wordReady_o,
  output logic                           lineValid_o,
  output logic [cachelineSizeInBits-1:0] cacheline_o,
  output logic [tagSize-1:0]             tag_o,
  output logic [indexSize-1:0]           index_o,
  input  logic                           lineReady_i,
  output logic                           criticalWordValid_o,
  output logic [wordSizeBits-1:0]        criticalWord_o
);

  localparam int wordsPerLine = cachelineSizeInBits / wordSizeBits;
  localparam int wordByteBits = $clog2(wordSizeBits / 8);
  localparam int ptrW         = $clog2(wordsPerLine);
  localparam logic [ptrW-1:0] lastSlot = ptrW'(wordsPerLine - 1);

  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_e;

  state_e                           state_q, state_d;
  logic [ptrW-1:0]                  ptr_q, ptr_d;
  logic [ptrW-1:0]                  cnt_q, cnt_d;
  logic [cachelineSizeInBits-1:0]   line_q, line_d;
  logic [tagSize-1:0]               tag_q, tag_d;
  logic [indexSize-1:0]             index_q, index_d;
  logic                             line_valid_q, line_valid_d;
  logic                             busy_q, busy_d;

  // Byte-within-word offset bits only matter to the requester, not to the fill order.
  logic unused_offset_bits;
  assign unused_offset_bits = ^startOffset_i[wordByteBits-1:0];

  // Next-state: start latches request, FILL writes words at a wrapping pointer, HOLD waits for the cache.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    line_d       = line_q;
    tag_d        = tag_q;
    index_d      = index_q;
    line_valid_d = line_valid_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          tag_d   = startTag_i;
          index_d = startIndex_i;
          ptr_d   = startOffset_i[offsetSize-1:wordByteBits];
          cnt_d   = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        if (wordValid_i) begin
          line_d[ptr_q*wordSizeBits +: wordSizeBits] = word_i;
          ptr_d = (ptr_q == lastSlot) ? '0 : ptr_q + ptrW'(1);
          cnt_d = cnt_q + ptrW'(1);
          if (cnt_q == lastSlot) begin
            state_d      = HOLD;
            line_valid_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (lineReady_i) begin
          line_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Flush overrides anything else happening in the same cycle, including the last word.
    if (flushPipeline_i) begin
      state_d      = IDLE;
      line_valid_d = 1'b0;
      tag_d        = '0;
      index_d      = '0;
      line_d       = '0;
      cnt_d        = '0;
    end
    busy_d = (state_d != IDLE);
  end

  // Single state/output register bank.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      line_q       <= '0;
      tag_q        <= '0;
      index_q      <= '0;
      line_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      line_q       <= line_d;
      tag_q        <= tag_d;
      index_q      <= index_d;
      line_valid_q <= line_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign wordReady_o = (state_q == FILL);
  assign busy_o      = busy_q;
  assign lineValid_o = line_valid_q;
  assign cacheline_o = line_q;
  assign tag_o       = tag_q;
  assign index_o     = index_q;

`ifdef CACHELINE_CRITICAL_WORD_FORWARD_EN
  logic                    crit_valid_q, crit_valid_d;
  logic [wordSizeBits-1:0] crit_word_q, crit_word_d;

  // Forward the first accepted word of a fill as a one-cycle pulse so decode can restart early.
  always_comb begin
    crit_valid_d = 1'b0;
    crit_word_d  = crit_word_q;
    if (flushPipeline_i) begin
      crit_word_d = '0;
    end else if ((state_q == FILL) && wordValid_i && (cnt_q == '0)) begin
      crit_valid_d = 1'b1;
      crit_word_d  = word_i;
    end
  end

  // Critical-word register.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      crit_valid_q <= 1'b0;
      crit_word_q  <= '0;
    end else begin
      crit_valid_q <= crit_valid_d;
      crit_word_q  <= crit_word_d;
    end
  end

  assign criticalWordValid_o = crit_valid_q;
  assign criticalWord_o      = crit_word_q;
`else
  assign criticalWordValid_o = 1'b0;
  assign criticalWord_o      = '0;
`endif

endmodule

// File: tb/tb_cacheline_fill_assembler.sv
// tb/tb_cacheline_fill_assembler.sv - randomized self-checking bench for cacheline_fill_assembler
module tb_cacheline_fill_assembler;

  localparam int OFFW  = 5;
  localparam int IDXW  = 8;
  localparam int TAGW  = 64 - (OFFW + IDXW);
  localparam int LINEW = (2 ** OFFW) * 8;
  localparam int WPL   = LINEW / 32;
`ifdef CACHELINE_CRITICAL_WORD_FORWARD_EN
  localparam bit CRIT = 1'b1;
`else
  localparam bit CRIT = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             start;
  logic [TAGW-1:0]  start_tag;
  logic [IDXW-1:0]  start_idx;
  logic [OFFW-1:0]  start_off;
  logic             busy;
  logic             word_valid;
  logic [31:0]      word;
  logic             word_ready;
  logic             line_valid;
  logic [LINEW-1:0] line;
  logic [TAGW-1:0]  tag;
  logic [IDXW-1:0]  idx;
  logic             line_ready;
  logic             crit_valid;
  logic [31:0]      crit_word;

  int vectors;
  int miscompares;

  logic [31:0]     fill_words [WPL];
  logic [31:0]     model_slots [WPL];
  logic [TAGW-1:0] exp_tag;
  logic [IDXW-1:0] exp_idx;

  cacheline_fill_assembler dut (
    .clock_i(clk), .reset_n_i(rst_n), .flushPipeline_i(flush),
    .start_i(start), .startTag_i(start_tag), .startIndex_i(start_idx),
    .startOffset_i(start_off), .busy_o(busy),
    .wordValid_i(word_valid), .word_i(word), .wordReady_o(word_ready),
    .lineValid_o(line_valid), .cacheline_o(line), .tag_o(tag), .index_o(idx),
    .lineReady_i(line_ready),
    .criticalWordValid_o(crit_valid), .criticalWord_o(crit_word)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LINEW-1:0] model_line();
    logic [LINEW-1:0] v;
    for (int k = 0; k < WPL; k++) v[k*32 +: 32] = model_slots[k];
    return v;
  endfunction

  // Critical-word-first placement: i-th returned word lands in slot (first + i) mod WPL.
  task automatic set_model(input logic [OFFW-1:0] off);
    int first;
    first = int'(off) / 4;
    for (int i = 0; i < WPL; i++) model_slots[(first + i) % WPL] = fill_words[i];
  endtask

  task automatic start_fill(input logic [TAGW-1:0] t, input logic [IDXW-1:0] x, input logic [OFFW-1:0] off);
    start = 1'b1; start_tag = t; start_idx = x; start_off = off;
    exp_tag = t; exp_idx = x;
    step();
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || word_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL start_fill: busy=%b ready=%b expected 1 1", busy, word_ready);
    end
  endtask

  // mode 0: back-to-back, 1: one bubble before each word, 2: random bubbles
  task automatic feed_words(input int n, input int mode);
    int bubbles;
    for (int i = 0; i < n; i++) begin
      bubbles = (mode == 0) ? 0 : (mode == 1) ? 1 : $urandom_range(0, 2);
      for (int b = 0; b < bubbles; b++) begin
        word_valid = 1'b0; word = $urandom;
        step();
      end
      vectors++;
      if (word_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL word_ready[%0d]: got %b expected 1", i, word_ready);
      end
      word_valid = 1'b1; word = fill_words[i];
      step();
      word_valid = 1'b0;
      vectors++;
      if (line_valid !== (i == WPL - 1)) begin
        miscompares++;
        $display("FAIL line_valid_timing[%0d]: got %b expected %b", i, line_valid, (i == WPL - 1));
      end
      vectors++;
      if (crit_valid !== (CRIT && i == 0)) begin
        miscompares++;
        $display("FAIL crit_valid[%0d]: got %b expected %b", i, crit_valid, (CRIT && i == 0));
      end
      vectors++;
      if (crit_word !== (CRIT ? fill_words[0] : 32'h0)) begin
        miscompares++;
        $display("FAIL crit_word[%0d]: got %h expected %h", i, crit_word, (CRIT ? fill_words[0] : 32'h0));
      end
    end
  endtask

  task automatic check_line(input string name);
    logic [LINEW-1:0] e;
    e = model_line();
    vectors++;
    if (line_valid !== 1'b1 || line !== e || tag !== exp_tag || idx !== exp_idx || word_ready !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s: valid=%b line=%h tag=%h idx=%h ready=%b busy=%b expected 1 %h %h %h 0 1",
               name, line_valid, line, tag, idx, word_ready, busy, e, exp_tag, exp_idx);
    end
  endtask

  task automatic handshake(input string name);
    line_ready = 1'b1;
    step();
    line_ready = 1'b0;
    vectors++;
    if (line_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_handshake: valid=%b busy=%b expected 0 0", name, line_valid, busy);
    end
  endtask

  task automatic check_all_zero(input string name);
    vectors++;
    if (busy !== 1'b0 || word_ready !== 1'b0 || line_valid !== 1'b0 || line !== '0 ||
        tag !== '0 || idx !== '0 || crit_valid !== 1'b0 || crit_word !== 32'h0) begin
      miscompares++;
      $display("FAIL %s: busy=%b ready=%b valid=%b line=%h tag=%h idx=%h cv=%b cw=%h expected all 0",
               name, busy, word_ready, line_valid, line, tag, idx, crit_valid, crit_word);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; start = 1'b0; start_tag = '0; start_idx = '0; start_off = '0;
    word_valid = 1'b0; word = '0; line_ready = 1'b0;
    step();
    step();
    check_all_zero("reset_state");
    rst_n = 1'b1;
    step();
    check_all_zero("post_reset_idle");
  endtask

  task automatic test_aligned_fill();
    for (int i = 0; i < WPL; i++) fill_words[i] = 32'hA0 + i;
    set_model(5'h00);
    start_fill(TAGW'(64'h1234), 8'h05, 5'h00);
    feed_words(WPL, 0);
    check_line("aligned_fill");
    handshake("aligned");
  endtask

  task automatic test_wrapped_fill();
    for (int i = 0; i < WPL; i++) fill_words[i] = 32'hB0 + i;
    set_model(5'h14);
    start_fill(TAGW'(64'h2BAD), 8'h9C, 5'h14);
    feed_words(WPL, 0);
    check_line("wrapped_fill");
    handshake("wrapped");
  endtask

  task automatic test_bubbles_backpressure();
    logic [LINEW-1:0] e;
    for (int i = 0; i < WPL; i++) fill_words[i] = 32'hC000_0000 | (i * 32'h1111);
    set_model(5'h0E);
    start_fill(TAGW'(64'h3_0000_0042), 8'h7F, 5'h0E);
    feed_words(WPL, 1);
    e = model_line();
    for (int c = 0; c < 5; c++) begin
      start = 1'b1; start_tag = TAGW'(64'hFFFF); start_idx = 8'h11; start_off = 5'h1F;
      word_valid = 1'b1; word = 32'hDEAD_BEEF;
      step();
      check_line("hold_stable");
    end
    start = 1'b0; word_valid = 1'b0;
    handshake("backpressure");
    step();
    vectors++;
    if (busy !== 1'b0 || line !== e) begin
      miscompares++;
      $display("FAIL idle_after_hold: busy=%b line=%h expected 0 %h", busy, line, e);
    end
  endtask

  task automatic test_flush_mid_fill();
    for (int i = 0; i < WPL; i++) fill_words[i] = 32'hF0 + i;
    start_fill(TAGW'(64'h77), 8'h33, 5'h08);
    feed_words(3, 0);
    flush = 1'b1; word_valid = 1'b1; word = 32'hDEAD;
    step();
    flush = 1'b0; word_valid = 1'b0;
    check_all_zero("flush_mid_fill");
    for (int i = 0; i < WPL; i++) fill_words[i] = 32'hE0 + i;
    set_model(5'h00);
    start_fill(TAGW'(64'h88), 8'h44, 5'h00);
    feed_words(WPL, 0);
    check_line("fill_after_flush");
    handshake("after_flush");
  endtask

  task automatic test_random_fills();
    logic [OFFW-1:0] off;
    int hold;
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < WPL; i++) fill_words[i] = $urandom;
      off = OFFW'($urandom_range(0, 31));
      set_model(off);
      start_fill(TAGW'({$urandom, $urandom}), IDXW'($urandom), off);
      feed_words(WPL, 2);
      check_line("random_fill");
      hold = $urandom_range(0, 3);
      for (int c = 0; c < hold; c++) begin
        step();
        check_line("random_hold");
      end
      handshake("random");
    end
  endtask

  task automatic test_async_reset_hold();
    for (int i = 0; i < WPL; i++) fill_words[i] = $urandom;
    set_model(5'h1C);
    start_fill(TAGW'(64'h5A5A), 8'hA5, 5'h1C);
    feed_words(WPL, 0);
    check_line("pre_reset_hold");
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset_immediate");
    #2 rst_n = 1'b1;
    step();
    check_all_zero("after_async_reset");
  endtask

  task automatic test_flush_last_word();
    for (int i = 0; i < WPL; i++) fill_words[i] = 32'h900 + i;
    start_fill(TAGW'(64'h99), 8'h01, 5'h04);
    feed_words(WPL - 1, 0);
    flush = 1'b1; word_valid = 1'b1; word = fill_words[WPL-1];
    step();
    flush = 1'b0; word_valid = 1'b0;
    check_all_zero("flush_with_last_word");
    for (int c = 0; c < 2; c++) begin
      step();
      vectors++;
      if (line_valid !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL flush_last_later: valid=%b busy=%b expected 0 0", line_valid, busy);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_aligned_fill();
    test_wrapped_fill();
    test_bubbles_backpressure();
    test_flush_mid_fill();
    test_random_fills();
    test_async_reset_hold();
    test_flush_last_word();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
